// File: rtl/seq_gen_pkg.sv
// Shared types and default parameters for the serial pattern generator.
// Build option: SEQ_GEN_PARITY_EN adds a parity bit after every pattern copy.
package seq_gen_pkg;

    localparam int PAT_W_DEF   = 4;
    localparam int CNT_W_DEF   = 4;
    localparam int GAP_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP    = 2'd2
`ifdef SEQ_GEN_PARITY_EN
        ,
        PARITY = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable MSB-first shift register plus bit counter.
// It holds the bits still to be sent after the one currently on the wire,
// left aligned, so next_bit_o is always the bit that follows the current one.
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [PAT_W-2:0] load_val_i,
    input  logic             shift_i,
    output logic             next_bit_o,
    output logic             last_o
);

    localparam int BC_W = $clog2(PAT_W);

    logic [PAT_W-2:0] sh_q, sh_d;
    logic [BC_W-1:0]  bc_q, bc_d;

    // Load restarts the bit count; a shift advances to the following bit.
    always_comb begin
        sh_d = sh_q;
        bc_d = bc_q;
        if (load_i) begin
            sh_d = load_val_i;
            bc_d = '0;
        end else if (shift_i) begin
            sh_d = sh_q << 1;
            bc_d = bc_q + BC_W'(1);
        end
    end

    // Shift register and bit counter storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
            bc_q <= '0;
        end else begin
            sh_q <= sh_d;
            bc_q <= bc_d;
        end
    end

    assign next_bit_o = sh_q[PAT_W-2];
    assign last_o     = (bc_q == BC_W'(PAT_W - 1));

endmodule

// File: rtl/seq_generator.sv
// Serial pattern generator: sends a latched pattern MSB first, repeated
// rep_cnt+1 times with idle gaps between copies, then pulses done.
// Build option: SEQ_GEN_PARITY_EN appends an even-parity bit to each copy.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pat_ready_q, pat_ready_d;

    logic             sh_load, sh_shift, sh_next, sh_last;
    logic [PAT_W-2:0] sh_val;
    logic             pat_end, reload;

    seq_gen_shreg #(
        .PAT_W(PAT_W)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (sh_load),
        .load_val_i(sh_val),
        .shift_i   (sh_shift),
        .next_bit_o(sh_next),
        .last_o    (sh_last)
    );

    // Next state and next values of every registered output; abort overrides last.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        sh_load     = 1'b0;
        sh_val      = pat_q[PAT_W-2:0];
        sh_shift    = 1'b0;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        pat_end     = 1'b0;
        reload      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pat_valid) begin
                    pat_d       = pat_data;
                    rep_d       = rep_cnt;
                    sh_load     = 1'b1;
                    sh_val      = pat_data[PAT_W-2:0];
                    state_d     = SHIFT;
                    out_d       = pat_data[PAT_W-1];
                    out_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (!sh_last) begin
                    sh_shift    = 1'b1;
                    out_d       = sh_next;
                    out_valid_d = 1'b1;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d     = PARITY;
                    out_d       = ^pat_q;
                    out_valid_d = 1'b1;
`else
                    pat_end     = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                pat_end = 1'b1;
            end
`endif
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    reload = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pat_end) begin
            if (rep_q != '0) begin
                rep_d = rep_q - CNT_W'(1);
                if (GAP_CYC == 0) begin
                    reload = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (reload) begin
            sh_load     = 1'b1;
            sh_val      = pat_q[PAT_W-2:0];
            state_d     = SHIFT;
            out_d       = pat_q[PAT_W-1];
            out_valid_d = 1'b1;
        end

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            sh_load     = 1'b0;
            sh_shift    = 1'b0;
            out_d       = 1'b0;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        pat_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pat_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pat_ready_q <= pat_ready_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pat_ready = pat_ready_q;

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator (PAT_W=4, CNT_W=4, GAP_CYC=2).
// Build option: SEQ_GEN_PARITY_EN expects a parity bit after each copy.
module tb_seq_generator;

`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pat_valid = 1'b0;
    logic       pat_ready;
    logic [3:0] pat_data = 4'h0;
    logic [3:0] rep_cnt = 4'h0;
    logic       abort = 1'b0;
    logic       out, out_valid, busy, done;

    int checks = 0;
    int errors = 0;

    seq_generator #(
        .PAT_W  (4),
        .CNT_W  (4),
        .GAP_CYC(GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pat_valid(pat_valid),
        .pat_ready(pat_ready),
        .pat_data (pat_data),
        .rep_cnt  (rep_cnt),
        .abort    (abort),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Check all observable outputs for the current cycle.
    task automatic checkCycle(input string tag, input logic eOut, input logic eValid,
                              input logic eBusy, input logic eDone, input logic eReady);
        checkOutput({tag, ".out"},       out,       eOut);
        checkOutput({tag, ".out_valid"}, out_valid, eValid);
        checkOutput({tag, ".busy"},      busy,      eBusy);
        checkOutput({tag, ".done"},      done,      eDone);
        checkOutput({tag, ".pat_ready"}, pat_ready, eReady);
    endtask

    // Walk a transfer from its first bit cycle to the done cycle (left unticked).
    task automatic applyStimulus(input string tag, input logic [3:0] pat, input int rep);
        for (int r = 0; r <= rep; r++) begin
            for (int i = 3; i >= 0; i--) begin
                checkCycle($sformatf("%s.c%0d.b%0d", tag, r, i), pat[i], 1'b1, 1'b1, 1'b0, 1'b0);
                tick();
            end
            if (PAR == 1) begin
                checkCycle($sformatf("%s.c%0d.par", tag, r), ^pat, 1'b1, 1'b1, 1'b0, 1'b0);
                tick();
            end
            if (r < rep) begin
                for (int g = 0; g < GAP; g++) begin
                    checkCycle($sformatf("%s.c%0d.gap%0d", tag, r, g), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    tick();
                end
            end
        end
        checkCycle({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Offer a request so the next edge accepts it, then settle in the first bit cycle.
    task automatic acceptRequest(input logic [3:0] pat, input logic [3:0] rep);
        pat_valid = 1'b1;
        pat_data  = pat;
        rep_cnt   = rep;
        tick();
        pat_valid = 1'b0;
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkCycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Single copy of 1001.
        acceptRequest(4'b1001, 4'd0);
        applyStimulus("single", 4'b1001, 0);
        tick();
        checkCycle("single.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Three copies of 1001 with two-cycle gaps.
        acceptRequest(4'b1001, 4'd2);
        applyStimulus("rep2", 4'b1001, 2);
        tick();

        // Different data offered while busy is ignored; held valid is taken in the done cycle.
        acceptRequest(4'b1101, 4'd0);
        pat_valid = 1'b1;
        pat_data  = 4'b0110;
        rep_cnt   = 4'd0;
        applyStimulus("busyign", 4'b1101, 0);
        tick();
        pat_valid = 1'b0;
        applyStimulus("b2b", 4'b0110, 0);
        tick();

        // Abort during cycle 2 of a repeated transfer.
        acceptRequest(4'b1001, 4'd1);
        checkCycle("abort.c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkCycle("abort.c2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkCycle("abort.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkCycle($sformatf("abort.quiet%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Abort coinciding with the last bit of the final copy: no done pulse.
        acceptRequest(4'b0111, 4'd0);
        tick();
        tick();
        tick();
        checkCycle("abortlast.b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        if (PAR == 1) begin
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkCycle("abortlast.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort together with a request while idle: the request is taken.
        abort     = 1'b1;
        pat_valid = 1'b1;
        pat_data  = 4'b1100;
        rep_cnt   = 4'd0;
        tick();
        abort     = 1'b0;
        pat_valid = 1'b0;
        applyStimulus("abortidle", 4'b1100, 0);
        tick();

        // Reset pulse mid-shift takes effect without a clock edge.
        acceptRequest(4'b1011, 4'd2);
        tick();
        #3 rst = 1'b1;
        #1;
        checkCycle("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkCycle($sformatf("midrst.quiet%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        acceptRequest(4'b0101, 4'd1);
        applyStimulus("postrst", 4'b0101, 1);
        tick();
        checkCycle("final", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
